// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and window bit mapping for the
// convolution window scheduler.
package conv_pkg;
  localparam int IMG_W  = 28;
  localparam int K      = 5;
  localparam int OUT_W  = IMG_W - K + 1;
  localparam int RD_LAT = 1;
  localparam int WIN_W  = K * K;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Window bit holding the pixel at row offset i, column offset j.
  function automatic int win_bit(input int j, input int i);
    return K * j + i;
  endfunction
endpackage

// File: rtl/conv_win_shift.sv
// Column history for the 5x5 sliding window plus registration of the
// window, its coordinates and the end-of-frame pulse.
module conv_win_shift
  import conv_pkg::*;
(
  input  logic             sclk,
  input  logic             s_rst,
  input  logic             tag_vld,
  input  logic [4:0]       tag_col,
  input  logic [4:0]       tag_row,
  input  logic [K-1:0]     col_data,
  output logic [WIN_W-1:0] win_data,
  output logic             win_vld,
  output logic [4:0]       win_row,
  output logic [4:0]       win_col,
  output logic             frame_done
);
  // Only the K-1 older columns are stored; the newest comes straight from col_data.
  logic [K-1:0]     hist_reg [K-1];
  logic [WIN_W-1:0] win_next;
  logic [WIN_W-1:0] win_data_reg;
  logic             win_vld_reg;
  logic [4:0]       win_row_reg;
  logic [4:0]       win_col_reg;
  logic             frame_done_reg;
  logic             emit;
  logic             last;

  for (genvar gi = 0; gi < K; gi++) begin : g_col
    for (genvar gk = 0; gk < K; gk++) begin : g_row
      if (gi == K - 1) begin : g_new
        assign win_next[win_bit(gi, gk)] = col_data[gk];
      end else begin : g_old
        assign win_next[win_bit(gi, gk)] = hist_reg[gi][gk];
      end
    end
  end

  // Columns 0..K-2 of a band only prime the history.
  assign emit = tag_vld && (tag_col >= 5'(K - 1));
  assign last = (tag_col == 5'(IMG_W - 1)) && (tag_row == 5'(OUT_W - 1));

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      for (int j = 0; j < K - 1; j++) hist_reg[j] <= '0;
      win_data_reg   <= '0;
      win_vld_reg    <= 1'b0;
      win_row_reg    <= '0;
      win_col_reg    <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      if (tag_vld) begin
        for (int j = 0; j < K - 2; j++) hist_reg[j] <= hist_reg[j + 1];
        hist_reg[K-2] <= col_data;
      end
      win_vld_reg    <= emit;
      win_data_reg   <= emit ? win_next : '0;
      win_row_reg    <= emit ? tag_row : '0;
      win_col_reg    <= emit ? (tag_col - 5'(K - 1)) : '0;
      frame_done_reg <= emit && last;
    end
  end

  assign win_data   = win_data_reg;
  assign win_vld    = win_vld_reg;
  assign win_row    = win_row_reg;
  assign win_col    = win_col_reg;
  assign frame_done = frame_done_reg;
endmodule

// File: rtl/conv_win_sched.sv
// Sweeps the bit-plane buffer band by band and turns the returned column
// slices into one tagged 5x5 binary window per cycle for the MAC array.
module conv_win_sched
  import conv_pkg::*;
(
  input  logic             sclk,
  input  logic             s_rst,
  input  logic             cal_start,
  input  logic [K-1:0]     col_data,
  output logic [4:0]       data_rd_addr,
  output logic [4:0]       conv_row_cnt,
  output logic [WIN_W-1:0] win_data,
  output logic             win_vld,
  output logic [4:0]       win_row,
  output logic [4:0]       win_col,
  output logic             frame_done,
  output logic             busy,
  output logic             start_ovf
);
  localparam int FW = $clog2(RD_LAT + 2);

  state_t        state_reg;
  state_t        state_next;
  logic [4:0]    addr_reg;
  logic [4:0]    row_reg;
  logic [FW-1:0] flush_cnt_reg;
  logic          start_ovf_reg;
  logic          busy_int;
  logic          issue;
  logic          last_addr;

  logic          tag_vld_pipe [RD_LAT];
  logic [4:0]    tag_col_pipe [RD_LAT];
  logic [4:0]    tag_row_pipe [RD_LAT];

  assign last_addr = (addr_reg == 5'(IMG_W - 1)) && (row_reg == 5'(OUT_W - 1));

  always_ff @(posedge sclk) begin
    if (s_rst) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cal_start) state_next = RUN;
      RUN:     if (last_addr) state_next = FLUSH;
      FLUSH:   if (flush_cnt_reg == FW'(RD_LAT)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_int = (state_reg != IDLE);
    issue    = (state_reg == RUN);
  end

  // Address/band counters run only in RUN and sit at zero otherwise.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      addr_reg      <= '0;
      row_reg       <= '0;
      flush_cnt_reg <= '0;
      start_ovf_reg <= 1'b0;
    end else begin
      start_ovf_reg <= cal_start && busy_int;
      flush_cnt_reg <= (state_reg == FLUSH) ? flush_cnt_reg + 1'b1 : '0;
      if (issue) begin
        if (addr_reg == 5'(IMG_W - 1)) begin
          addr_reg <= '0;
          row_reg  <= (row_reg == 5'(OUT_W - 1)) ? '0 : row_reg + 5'd1;
        end else begin
          addr_reg <= addr_reg + 5'd1;
        end
      end else begin
        addr_reg <= '0;
        row_reg  <= '0;
      end
    end
  end

  // Delay the issue tag by the buffer read latency so it lines up with col_data.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      for (int s = 0; s < RD_LAT; s++) begin
        tag_vld_pipe[s] <= 1'b0;
        tag_col_pipe[s] <= '0;
        tag_row_pipe[s] <= '0;
      end
    end else begin
      tag_vld_pipe[0] <= issue;
      tag_col_pipe[0] <= addr_reg;
      tag_row_pipe[0] <= row_reg;
      for (int s = 1; s < RD_LAT; s++) begin
        tag_vld_pipe[s] <= tag_vld_pipe[s-1];
        tag_col_pipe[s] <= tag_col_pipe[s-1];
        tag_row_pipe[s] <= tag_row_pipe[s-1];
      end
    end
  end

  conv_win_shift u_shift (
    .sclk       (sclk),
    .s_rst      (s_rst),
    .tag_vld    (tag_vld_pipe[RD_LAT-1]),
    .tag_col    (tag_col_pipe[RD_LAT-1]),
    .tag_row    (tag_row_pipe[RD_LAT-1]),
    .col_data   (col_data),
    .win_data   (win_data),
    .win_vld    (win_vld),
    .win_row    (win_row),
    .win_col    (win_col),
    .frame_done (frame_done)
  );

  assign data_rd_addr = addr_reg;
  assign conv_row_cnt = row_reg;
  assign busy         = busy_int;
  assign start_ovf    = start_ovf_reg;
endmodule

// File: tb/tb_conv_win_sched.sv
// Bench for conv_win_sched: buffer model, per-cycle output log and
// scenario tasks compared against a pixel-level window model.
module tb_conv_win_sched;
  localparam int LOGN = 1400;

  logic        sclk = 1'b0;
  logic        s_rst;
  logic        cal_start;
  logic [4:0]  col_data;
  logic [4:0]  data_rd_addr;
  logic [4:0]  conv_row_cnt;
  logic [24:0] win_data;
  logic        win_vld;
  logic [4:0]  win_row;
  logic [4:0]  win_col;
  logic        frame_done;
  logic        busy;
  logic        start_ovf;

  typedef struct packed {
    logic        vld;
    logic [4:0]  row;
    logic [4:0]  col;
    logic [24:0] data;
    logic        fd;
    logic        busy;
    logic        ovf;
    logic [4:0]  addr;
    logic [4:0]  band;
  } snap_t;

  snap_t lg [LOGN];
  int    cyc      = 0;
  int    t0       = 0;
  bit    logging  = 1'b0;
  int    bad_rng  = 0;
  int    checks   = 0;
  int    errors   = 0;
  int    buf_mode = 0;
  bit    img [28][28];

  always #5 sclk = ~sclk;

  conv_win_sched dut (
    .sclk         (sclk),
    .s_rst        (s_rst),
    .cal_start    (cal_start),
    .col_data     (col_data),
    .data_rd_addr (data_rd_addr),
    .conv_row_cnt (conv_row_cnt),
    .win_data     (win_data),
    .win_vld      (win_vld),
    .win_row      (win_row),
    .win_col      (win_col),
    .frame_done   (frame_done),
    .busy         (busy),
    .start_ovf    (start_ovf)
  );

  always @(posedge sclk) cyc <= cyc + 1;

  // Buffer model: mode 0 returns the column address, mode 1 reads img,
  // mode 2 returns all ones in band 0 and zeros elsewhere.
  function automatic logic [4:0] buf_read(input logic [4:0] a, input logic [4:0] b);
    logic [4:0] t;
    t = '0;
    case (buf_mode)
      0: t = a;
      1: for (int i = 0; i < 5; i++)
           if (int'(b) + i < 28 && int'(a) < 28) t[i] = img[int'(b) + i][int'(a)];
      default: t = (b == 5'd0) ? 5'h1F : 5'h00;
    endcase
    return t;
  endfunction

  always @(posedge sclk) col_data <= buf_read(data_rd_addr, conv_row_cnt);

  always @(negedge sclk) begin
    if (logging && (cyc - t0) >= 0 && (cyc - t0) < LOGN)
      lg[cyc - t0] <= '{vld: win_vld, row: win_row, col: win_col, data: win_data,
                        fd: frame_done, busy: busy, ovf: start_ovf,
                        addr: data_rd_addr, band: conv_row_cnt};
    if (data_rd_addr > 5'd27 || conv_row_cnt > 5'd23) bad_rng <= bad_rng + 1;
  end

  // Reference window: bit 5*j+i is pixel (r+i, c+j).
  function automatic logic [24:0] model_win(input int r, input int c);
    logic [24:0] w;
    w = '0;
    for (int j = 0; j < 5; j++)
      for (int i = 0; i < 5; i++)
        w[5*j + i] = img[r + i][c + j];
    return w;
  endfunction

  function automatic logic [24:0] ramp_win(input int c);
    logic [24:0] w;
    w = '0;
    for (int j = 0; j < 5; j++) w[5*j +: 5] = 5'(c + j);
    return w;
  endfunction

  function automatic int cnt_vld(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++) if (lg[k].vld === 1'b1) n++;
    return n;
  endfunction

  function automatic int cnt_fd(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++) if (lg[k].fd === 1'b1) n++;
    return n;
  endfunction

  function automatic int cnt_ovf(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++) if (lg[k].ovf === 1'b1) n++;
    return n;
  endfunction

  task automatic goto(input int rel);
    while (cyc - t0 < rel) begin
      @(posedge sclk);
      #1;
    end
  endtask

  task automatic do_reset;
    s_rst     = 1'b1;
    cal_start = 1'b0;
    repeat (3) @(posedge sclk);
    #1;
    s_rst = 1'b0;
  endtask

  task automatic begin_frame;
    @(posedge sclk);
    #1;
    t0        = cyc;
    logging   = 1'b1;
    cal_start = 1'b1;
    goto(1);
    cal_start = 1'b0;
  endtask

  task automatic random_image;
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) img[r][c] = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset;
    s_rst     = 1'b1;
    cal_start = 1'b1;
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    checks++;
    if ({win_vld, win_data, win_row, win_col, frame_done, busy, start_ovf,
         data_rd_addr, conv_row_cnt} !== 49'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {win_vld, win_data, win_row, win_col,
               frame_done, busy, start_ovf, data_rd_addr, conv_row_cnt});
    end
    @(posedge sclk);
    #1;
    s_rst     = 1'b0;
    cal_start = 1'b0;
    @(negedge sclk);
    checks++;
    if ({busy, start_ovf, win_vld} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: busy/ovf/vld got %b want 000", {busy, start_ovf, win_vld});
    end
  endtask

  task automatic test_ramp;
    int idx;
    int shown;
    int nv;
    do_reset();
    buf_mode = 0;
    begin_frame();
    goto(700);
    checks++;
    if (lg[6].vld !== 1'b0) begin
      errors++; $display("FAIL ramp_early_vld: got %b want 0", lg[6].vld);
    end
    checks++;
    if ({lg[7].vld, lg[7].row, lg[7].col, lg[7].data} !== {1'b1, 5'd0, 5'd0, ramp_win(0)}) begin
      errors++;
      $display("FAIL ramp_first_win: got vld=%b row=%0d col=%0d data=%h want 1 0 0 %h",
               lg[7].vld, lg[7].row, lg[7].col, lg[7].data, ramp_win(0));
    end
    checks++;
    if ({lg[0].busy, lg[1].busy, lg[674].busy, lg[675].busy} !== 4'b0110) begin
      errors++;
      $display("FAIL ramp_busy: got %b want 0110",
               {lg[0].busy, lg[1].busy, lg[674].busy, lg[675].busy});
    end
    checks++;
    if ({lg[1].addr, lg[2].addr, lg[672].addr, lg[672].band, lg[673].addr, lg[673].band} !==
        {5'd0, 5'd1, 5'd27, 5'd23, 5'd0, 5'd0}) begin
      errors++;
      $display("FAIL ramp_addr: got %0d %0d %0d/%0d %0d/%0d want 0 1 27/23 0/0",
               lg[1].addr, lg[2].addr, lg[672].addr, lg[672].band, lg[673].addr, lg[673].band);
    end
    checks++;
    if (cnt_fd(0, 699) != 1 || lg[674].fd !== 1'b1) begin
      errors++;
      $display("FAIL ramp_frame_done: got count=%0d at674=%b want 1 1", cnt_fd(0, 699), lg[674].fd);
    end
    nv = cnt_vld(0, 699);
    checks++;
    if (nv != 576) begin
      errors++; $display("FAIL ramp_count: got %0d want 576", nv);
    end
    shown = 0;
    for (int r = 0; r < 24; r++) begin
      for (int c = 0; c < 24; c++) begin
        idx = 7 + r * 28 + c;
        checks++;
        if ({lg[idx].vld, lg[idx].row, lg[idx].col, lg[idx].data} !==
            {1'b1, 5'(r), 5'(c), ramp_win(c)}) begin
          errors++;
          if (shown < 4)
            $display("FAIL ramp_win r=%0d c=%0d: got vld=%b row=%0d col=%0d data=%h want data=%h",
                     r, c, lg[idx].vld, lg[idx].row, lg[idx].col, lg[idx].data, ramp_win(c));
          shown++;
        end
      end
    end
    $display("test_ramp: windows=%0d", nv);
  endtask

  task automatic test_random_image;
    int idx;
    int shown;
    int nv;
    do_reset();
    random_image();
    buf_mode = 1;
    begin_frame();
    goto(700);
    nv = cnt_vld(0, 699);
    checks++;
    if (nv != 576) begin
      errors++; $display("FAIL rand_count: got %0d want 576", nv);
    end
    shown = 0;
    for (int r = 0; r < 24; r++) begin
      for (int c = 0; c < 24; c++) begin
        idx = 7 + r * 28 + c;
        checks++;
        if ({lg[idx].vld, lg[idx].row, lg[idx].col, lg[idx].data} !==
            {1'b1, 5'(r), 5'(c), model_win(r, c)}) begin
          errors++;
          if (shown < 4)
            $display("FAIL rand_win r=%0d c=%0d: got vld=%b row=%0d col=%0d data=%h want data=%h",
                     r, c, lg[idx].vld, lg[idx].row, lg[idx].col, lg[idx].data, model_win(r, c));
          shown++;
        end
      end
    end
    $display("test_random_image: windows=%0d", nv);
  endtask

  task automatic test_single_pixel;
    int idx;
    int shown;
    int nz;
    logic [24:0] exp_w;
    do_reset();
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) img[r][c] = 1'b0;
    img[10][12] = 1'b1;
    buf_mode = 1;
    begin_frame();
    goto(700);
    shown = 0;
    nz    = 0;
    for (int r = 0; r < 24; r++) begin
      for (int c = 0; c < 24; c++) begin
        idx   = 7 + r * 28 + c;
        exp_w = '0;
        if (r >= 6 && r <= 10 && c >= 8 && c <= 12) exp_w[5*(12 - c) + (10 - r)] = 1'b1;
        if (lg[idx].data !== 25'd0) nz++;
        checks++;
        if (lg[idx].vld !== 1'b1 || lg[idx].data !== exp_w) begin
          errors++;
          if (shown < 4)
            $display("FAIL pixel_win r=%0d c=%0d: got vld=%b data=%h want 1 %h",
                     r, c, lg[idx].vld, lg[idx].data, exp_w);
          shown++;
        end
      end
    end
    checks++;
    if (nz != 25) begin
      errors++; $display("FAIL pixel_nonzero: got %0d want 25", nz);
    end
    $display("test_single_pixel: nonzero windows=%0d", nz);
  endtask

  task automatic test_band_boundary;
    int bad;
    do_reset();
    buf_mode = 2;
    begin_frame();
    goto(100);
    bad = 0;
    for (int k = 7; k <= 30; k++)
      if ({lg[k].vld, lg[k].row, lg[k].col} !== {1'b1, 5'd0, 5'(k - 7)}) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL band0_cols: got %0d bad cycles want 0", bad);
    end
    checks++;
    if ({lg[31].vld, lg[32].vld, lg[33].vld, lg[34].vld} !== 4'b0000) begin
      errors++;
      $display("FAIL band_gap: got %b want 0000", {lg[31].vld, lg[32].vld, lg[33].vld, lg[34].vld});
    end
    checks++;
    if ({lg[35].vld, lg[35].row, lg[35].col, lg[35].data} !== {1'b1, 5'd1, 5'd0, 25'd0}) begin
      errors++;
      $display("FAIL band1_first: got vld=%b row=%0d col=%0d data=%h want 1 1 0 0",
               lg[35].vld, lg[35].row, lg[35].col, lg[35].data);
    end
    checks++;
    if (lg[30].data !== 25'h1FFFFFF) begin
      errors++; $display("FAIL band0_last_data: got %h want 1ffffff", lg[30].data);
    end
    $display("test_band_boundary: band1 first window data=%h", lg[35].data);
  endtask

  task automatic test_start_ovf;
    do_reset();
    buf_mode = 0;
    begin_frame();
    goto(100);
    cal_start = 1'b1;
    goto(101);
    cal_start = 1'b0;
    goto(700);
    checks++;
    if ({lg[100].ovf, lg[101].ovf, lg[102].ovf} !== 3'b010 || cnt_ovf(0, 699) != 1) begin
      errors++;
      $display("FAIL ovf_pulse: got %b count=%0d want 010 count=1",
               {lg[100].ovf, lg[101].ovf, lg[102].ovf}, cnt_ovf(0, 699));
    end
    checks++;
    if (lg[674].fd !== 1'b1 || cnt_fd(0, 699) != 1 || cnt_vld(0, 699) != 576) begin
      errors++;
      $display("FAIL ovf_frame: got fd674=%b fds=%0d wins=%0d want 1 1 576",
               lg[674].fd, cnt_fd(0, 699), cnt_vld(0, 699));
    end
    $display("test_start_ovf: ovf pulses=%0d", cnt_ovf(0, 699));
  endtask

  task automatic test_reset_mid;
    int idx;
    int shown;
    do_reset();
    random_image();
    buf_mode = 1;
    begin_frame();
    goto(300);
    s_rst = 1'b1;
    goto(301);
    s_rst = 1'b0;
    goto(700);
    checks++;
    if (lg[300].busy !== 1'b1 ||
        {lg[301].vld, lg[301].data, lg[301].row, lg[301].col, lg[301].fd, lg[301].busy,
         lg[301].ovf, lg[301].addr, lg[301].band} !== 49'd0) begin
      errors++;
      $display("FAIL midrst_outputs: got busy300=%b snap301=%h want 1 0", lg[300].busy, lg[301]);
    end
    checks++;
    if (cnt_vld(302, 699) != 0 || cnt_fd(0, 699) != 0) begin
      errors++;
      $display("FAIL midrst_quiet: got wins=%0d fds=%0d want 0 0", cnt_vld(302, 699), cnt_fd(0, 699));
    end
    begin_frame();
    goto(700);
    checks++;
    if (cnt_vld(0, 699) != 576 || lg[674].fd !== 1'b1) begin
      errors++;
      $display("FAIL midrst_refrm: got wins=%0d fd674=%b want 576 1", cnt_vld(0, 699), lg[674].fd);
    end
    shown = 0;
    for (int r = 0; r < 24; r += 7) begin
      for (int c = 0; c < 24; c++) begin
        idx = 7 + r * 28 + c;
        checks++;
        if ({lg[idx].vld, lg[idx].row, lg[idx].col, lg[idx].data} !==
            {1'b1, 5'(r), 5'(c), model_win(r, c)}) begin
          errors++;
          if (shown < 4)
            $display("FAIL midrst_win r=%0d c=%0d: got data=%h want %h",
                     r, c, lg[idx].data, model_win(r, c));
          shown++;
        end
      end
    end
    $display("test_reset_mid: refrm windows=%0d", cnt_vld(0, 699));
  endtask

  task automatic test_back_to_back;
    do_reset();
    buf_mode = 0;
    begin_frame();
    goto(674);
    cal_start = 1'b1;
    goto(676);
    cal_start = 1'b0;
    goto(1400);
    checks++;
    if ({lg[674].fd, lg[675].ovf, lg[676].ovf} !== 3'b110) begin
      errors++;
      $display("FAIL b2b_ovf: got fd674/ovf675/ovf676=%b want 110",
               {lg[674].fd, lg[675].ovf, lg[676].ovf});
    end
    checks++;
    if ({lg[681].vld, lg[682].vld, lg[682].row, lg[682].col, lg[682].data} !==
        {1'b0, 1'b1, 5'd0, 5'd0, ramp_win(0)}) begin
      errors++;
      $display("FAIL b2b_first_win: got vld681=%b vld682=%b row=%0d col=%0d data=%h want 0 1 0 0 %h",
               lg[681].vld, lg[682].vld, lg[682].row, lg[682].col, lg[682].data, ramp_win(0));
    end
    checks++;
    if (cnt_vld(0, 1399) != 1152 || cnt_fd(0, 1399) != 2 || lg[1349].fd !== 1'b1) begin
      errors++;
      $display("FAIL b2b_frames: got wins=%0d fds=%0d fd1349=%b want 1152 2 1",
               cnt_vld(0, 1399), cnt_fd(0, 1399), lg[1349].fd);
    end
    checks++;
    if (bad_rng != 0) begin
      errors++; $display("FAIL addr_range: got %0d out-of-range cycles want 0", bad_rng);
    end
    $display("test_back_to_back: windows=%0d", cnt_vld(0, 1399));
  endtask

  initial begin
    s_rst     = 1'b1;
    cal_start = 1'b0;
    test_reset();
    test_ramp();
    test_random_image();
    test_single_pixel();
    test_band_boundary();
    test_start_ovf();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_win_sched.md
Name: conv_win_sched

Overview:
- Scheduler/read sequencer for the 28-row bit-plane image buffer written by the downsampler.
- On the buffer's cal_start pulse it sweeps conv_row_cnt (band select, 0..23) and data_rd_addr (column, 0..27) across the whole buffer.
- It collects the returned 5-bit column slices into a 5x5 sliding window and presents one 25-bit binary window per cycle to the convolution engine, tagged with its output coordinates.
- It sits between the image buffer and the conv MAC array.

Parameters:
- IMG_W, 28, image width/height (square), columns per band.
- K, 5, kernel size; OUT_W = IMG_W-K+1 = 24 output rows and columns.
- RD_LAT, 1, buffer read latency in cycles (address to col_data).

Ports:
- sclk  in  1  system clock; one clock, all logic on rising edge.
- s_rst  in  1  synchronous, active-high reset.
- cal_start  in  1  one-cycle pulse from the image buffer: frame fully written.
- col_data  in  5  buffer read data; bit i = pixel (conv_row_cnt+i, data_rd_addr), valid RD_LAT cycles after the address.
- data_rd_addr  out  5  buffer column read address.
- conv_row_cnt  out  5  buffer band select, 0..23.
- win_data  out  25  window; bit 5*j+i = pixel (win_row+i, win_col+j).
- win_vld  out  1  win_data/win_row/win_col valid this cycle.
- win_row  out  5  output row 0..23.
- win_col  out  5  output column 0..23.
- frame_done  out  1  one-cycle pulse, coincident with the 576th win_vld.
- busy  out  1  high from the first RUN cycle through the frame_done cycle.
- start_ovf  out  1  one-cycle pulse: cal_start arrived while busy.

Behaviour:
- Reset: all outputs 0, state IDLE, window shift register cleared, tag pipeline cleared.
- FSM IDLE -> RUN -> FLUSH -> IDLE.
  - IDLE: addr = 0, row = 0. cal_start -> RUN next cycle.
  - RUN: one address per cycle. addr increments 0..27. At addr 27 it wraps to 0 and row increments. At addr 27 with row 23 -> FLUSH.
  - FLUSH: lasts RD_LAT+1 cycles while the final reads drain, then -> IDLE.
  - Outputs hold 0 in FLUSH and IDLE.
- Tag pipeline: {addr, row, issue_valid} is delayed RD_LAT cycles so it aligns with col_data.
- Window update, in the cycle aligned data is valid:
  - Shift register shifts toward lower j; col_data is loaded into j = 4.
  - If the aligned col tag >= 4: registered win_vld = 1, win_col = tag-4, win_row = row tag.
  - Otherwise win_vld = 0. The first 4 columns of each band only prime the window, so stale columns from the previous band are never emitted.
- Timing with RD_LAT = 1 and cal_start high in cycle 0:
  - addr 0 in cycle 1.
  - First win_vld (row 0, col 0) in cycle 7.
  - Last addr in cycle 672.
  - Last win_vld + frame_done in cycle 674; busy falls after cycle 674.
  - Windows are contiguous within a band: 24 consecutive win_vld, then a 4-cycle gap.
- Exactly 576 windows per frame.
- cal_start while busy: ignored (no restart) and start_ovf pulses the next cycle.
- cal_start in the same cycle as frame_done: counts as busy, so start_ovf pulses.
- cal_start in the first IDLE cycle after frame_done: accepted normally.
- s_rst mid-frame: immediate return to IDLE; all outputs 0 the next cycle; no frame_done.
- conv_row_cnt never exceeds 23; data_rd_addr never exceeds 27.

Decomposition:
- Package conv_pkg holds:
  - IMG_W, K, OUT_W, RD_LAT constants;
  - FSM state enum (IDLE, RUN, FLUSH);
  - window bit-index helper constant (5*j+i mapping).
- One sub-module, conv_win_shift: the 5x5 shift register plus the col-tag >= 4 valid/coordinate registration.
- Counters, FSM and tag pipeline stay in the top module.

Test Plan:
- Reset then cal_start in cycle 0 with buffer model returning col_data = addr[4:0]:
  - first win_vld in cycle 7, win_row 0, win_col 0, win_data = {5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
  - frame_done in cycle 674;
  - exactly 576 win_vld.
- Buffer model loaded with a single pixel set at (10,12):
  - exactly those windows with win_row 6..10 and win_col 8..12 have one bit set, at bit 5*(12-win_col)+(10-win_row);
  - all other windows are 0.
- Band boundary: check win_col sequence 0..23, then 4 cycles with win_vld = 0, then win_row 1 / win_col 0.
  - Window (1,0) must contain no band-0 columns.
- cal_start re-pulsed at cycle 100:
  - start_ovf = 1 at cycle 101;
  - frame unaffected (frame_done still at cycle 674).
- s_rst at cycle 300:
  - cycle 301 shows all outputs 0 and IDLE;
  - a new cal_start yields a full 576-window frame.
- Back-to-back frames:
  - cal_start in the frame_done cycle -> start_ovf;
  - cal_start one cycle later -> accepted, first win_vld 7 cycles after it.
